// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional bubble counter is enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage_reg #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ValidD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            MemReadD,
    input  logic            ALUSrcD,
    input  logic            ResultSrcD,
    input  logic [2:0]      BranchD,
    input  logic [2:0]      ALUControlD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdD,
    input  logic            StallE,
    input  logic            FlushE,
    output logic            ValidE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            MemReadE,
    output logic            ALUSrcE,
    output logic            ResultSrcE,
    output logic [2:0]      BranchE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [REGW-1:0] Rs1E,
    output logic [REGW-1:0] Rs2E,
    output logic [REGW-1:0] RdE,
`ifdef ID_EX_BUBBLE_CNT_EN
    output logic [31:0]     BubbleCount,
`endif
    output logic            LoadUseStall
);

    logic bubble;
    logic update;

    assign LoadUseStall = ValidE & MemReadE & (RdE != '0) & ValidD
                        & ((RdE == Rs1D) | (RdE == Rs2D));

    // Flush beats stall; a held stage never inserts a load-use bubble.
    assign bubble = FlushE | (~StallE & LoadUseStall);
    assign update = FlushE | ~StallE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            MemReadE    <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= 1'b0;
            BranchE     <= '0;
            ALUControlE <= '0;
            PCE         <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
        end else if (update) begin
            ValidE      <= bubble ? 1'b0 : ValidD;
            RegWriteE   <= bubble ? 1'b0 : RegWriteD;
            MemWriteE   <= bubble ? 1'b0 : MemWriteD;
            MemReadE    <= bubble ? 1'b0 : MemReadD;
            ALUSrcE     <= bubble ? 1'b0 : ALUSrcD;
            ResultSrcE  <= bubble ? 1'b0 : ResultSrcD;
            BranchE     <= bubble ? 3'b000 : BranchD;
            ALUControlE <= bubble ? 3'b000 : ALUControlD;
            // Datapath fields load even on a bubble; nothing downstream uses them.
            PCE         <= PCD;
            RD1E        <= RD1D;
            RD2E        <= RD2D;
            ImmExtE     <= ImmExtD;
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            RdE         <= RdD;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            BubbleCount <= '0;
        else if (bubble && (BubbleCount != 32'hFFFF_FFFF))
            BubbleCount <= BubbleCount + 32'd1;
    end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg (counter checks only when
// ID_EX_BUBBLE_CNT_EN is defined).
module tb_id_ex_stage_reg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    logic            clk, rst_n;
    logic            ValidD, RegWriteD, MemWriteD, MemReadD, ALUSrcD, ResultSrcD;
    logic [2:0]      BranchD, ALUControlD;
    logic [XLEN-1:0] PCD, RD1D, RD2D, ImmExtD;
    logic [REGW-1:0] Rs1D, Rs2D, RdD;
    logic            StallE, FlushE;
    logic            ValidE, RegWriteE, MemWriteE, MemReadE, ALUSrcE, ResultSrcE;
    logic [2:0]      BranchE, ALUControlE;
    logic [XLEN-1:0] PCE, RD1E, RD2E, ImmExtE;
    logic [REGW-1:0] Rs1E, Rs2E, RdE;
    logic            LoadUseStall;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0]     BubbleCount;
`endif

    int vecs = 0;
    int errs = 0;

    id_ex_stage_reg #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ValidD(ValidD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
        .MemReadD(MemReadD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
        .BranchD(BranchD), .ALUControlD(ALUControlD),
        .PCD(PCD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .StallE(StallE), .FlushE(FlushE),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .MemReadE(MemReadE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .BranchE(BranchE), .ALUControlE(ALUControlE),
        .PCE(PCE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
`ifdef ID_EX_BUBBLE_CNT_EN
        .BubbleCount(BubbleCount),
`endif
        .LoadUseStall(LoadUseStall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_d();
        ValidD = 0; RegWriteD = 0; MemWriteD = 0; MemReadD = 0;
        ALUSrcD = 0; ResultSrcD = 0; BranchD = 0; ALUControlD = 0;
        PCD = 0; RD1D = 0; RD2D = 0; ImmExtD = 0;
        Rs1D = 0; Rs2D = 0; RdD = 0;
    endtask

    initial begin
        rst_n = 0; StallE = 0; FlushE = 0;
        clear_d();
        #3;
        chk("rst_valid", ValidE, 0);
        chk("rst_regwrite", RegWriteE, 0);
        chk("rst_rd", RdE, 0);
        chk("rst_lus", LoadUseStall, 0);
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("rst_cnt", BubbleCount, 0);
`endif
        @(negedge clk);
        rst_n = 1;

        // Single pass
        ValidD = 1; RegWriteD = 1; ALUControlD = 3'b010; RD1D = 32'h11; RdD = 5;
        tick();
        chk("pass_valid", ValidE, 1);
        chk("pass_regwrite", RegWriteE, 1);
        chk("pass_aluctl", ALUControlE, 3'b010);
        chk("pass_rd1", RD1E, 32'h11);
        chk("pass_rd", RdE, 5);

        // Load-use on Rs2
        clear_d();
        ValidD = 1; MemReadD = 1; RegWriteD = 1; ResultSrcD = 1; RdD = 7; Rs1D = 1; Rs2D = 2;
        tick();
        chk("load_memread", MemReadE, 1);
        clear_d();
        ValidD = 1; RegWriteD = 1; Rs1D = 3; Rs2D = 7; RdD = 8;
        #1;
        chk("lu_stall", LoadUseStall, 1);
        tick();
        chk("lu_bub_valid", ValidE, 0);
        chk("lu_bub_regwrite", RegWriteE, 0);
        chk("lu_bub_memread", MemReadE, 0);
        chk("lu_drop", LoadUseStall, 0);
        tick();
        chk("lu_after_valid", ValidE, 1);
        chk("lu_after_rd", RdE, 8);

        // Load into x0 never stalls
        clear_d();
        ValidD = 1; MemReadD = 1; RdD = 0;
        tick();
        clear_d();
        ValidD = 1; RegWriteD = 1; Rs1D = 0; Rs2D = 0; RdD = 9;
        #1;
        chk("x0_lus", LoadUseStall, 0);
        tick();
        chk("x0_pass_valid", ValidE, 1);
        chk("x0_pass_rd", RdE, 9);

        // Invalid load in EX never stalls
        clear_d();
        ValidD = 0; MemReadD = 1; RdD = 7;
        tick();
        chk("inv_memread", MemReadE, 1);
        chk("inv_valid", ValidE, 0);
        clear_d();
        ValidD = 1; RegWriteD = 1; Rs2D = 7; RdD = 10;
        #1;
        chk("inv_lus", LoadUseStall, 0);
        tick();
        chk("inv_pass_valid", ValidE, 1);
        chk("inv_pass_rd", RdE, 10);

        // Flush beats stall, store squashed
        clear_d();
        ValidD = 1; MemWriteD = 1; BranchD = 3'b001; FlushE = 1; StallE = 1;
        tick();
        chk("fl_memwrite", MemWriteE, 0);
        chk("fl_valid", ValidE, 0);
        chk("fl_branch", BranchE, 0);
        StallE = 0;
        clear_d();
        ValidD = 1; RegWriteD = 1; ALUSrcD = 1; RdD = 11;
        tick();
        chk("fl2_valid", ValidE, 0);
        chk("fl2_regwrite", RegWriteE, 0);
        chk("fl2_alusrc", ALUSrcE, 0);
        FlushE = 0;
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("cnt_three", BubbleCount, 3);
`endif

        // Hold for three edges with changing D inputs
        clear_d();
        ValidD = 1; RegWriteD = 1; ALUControlD = 3'b110; RD1D = 32'hAA; RdD = 12; Rs1D = 4; Rs2D = 5;
        tick();
        chk("hold_load_rd", RdE, 12);
        StallE = 1;
        for (int i = 0; i < 3; i++) begin
            ValidD = i[0]; RD1D = 32'h100 + i; RdD = 13 + i; ALUControlD = 3'(i);
            MemWriteD = 1;
            tick();
            chk("hold_rd1", RD1E, 32'hAA);
            chk("hold_rd", RdE, 12);
            chk("hold_aluctl", ALUControlE, 3'b110);
            chk("hold_valid", ValidE, 1);
            chk("hold_memwrite", MemWriteE, 0);
`ifdef ID_EX_BUBBLE_CNT_EN
            chk("hold_cnt", BubbleCount, 3);
`endif
        end
        StallE = 0;

        // Reset mid-cycle with a load-use pending
        clear_d();
        ValidD = 1; MemReadD = 1; RdD = 6;
        tick();
        clear_d();
        ValidD = 1; Rs1D = 6; RdD = 2;
        #1;
        chk("pre_rst_lus", LoadUseStall, 1);
        #1;
        rst_n = 0;
        #1;
        chk("midrst_valid", ValidE, 0);
        chk("midrst_lus", LoadUseStall, 0);
        chk("midrst_rd", RdE, 0);
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("midrst_cnt", BubbleCount, 0);
`endif
        @(negedge clk);
        rst_n = 1;
        clear_d();
        tick();
        chk("post_rst_valid", ValidE, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register for the five-stage RISC-V core. It sits directly downstream of the decode-stage control unit and register file. It captures the decoded control bundle plus operand data at each clock edge and presents it to the execute stage. It also contains the load-use hazard detector, and inserts bubbles on load-use hazards and execute-stage flushes.

## Interface
Parameters:
- XLEN, 32, datapath width of PC, operands and immediate
- REGW, 5, register index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ValidD  in  1  decode stage holds a real instruction
- RegWriteD, MemWriteD, MemReadD, ALUSrcD, ResultSrcD  in  1 each  decoded control
- BranchD  in  3  branch type
- ALUControlD  in  3  ALU operation
- PCD, RD1D, RD2D, ImmExtD  in  XLEN each  PC, operands, extended immediate
- Rs1D, Rs2D, RdD  in  REGW each  register indices
- StallE  in  1  hold register contents (memory-stage stall)
- FlushE  in  1  branch/jump taken in EX; squash instruction entering EX
- ValidE, RegWriteE, MemWriteE, MemReadE, ALUSrcE, ResultSrcE  out  1 each  registered control
- BranchE, ALUControlE  out  3 each
- PCE, RD1E, RD2E, ImmExtE  out  XLEN each
- Rs1E, Rs2E, RdE  out  REGW each
- LoadUseStall  out  1  combinational; top level uses it to freeze PC and IF/ID
- BubbleCount  out  32  bubbles inserted (present only with the macro below)

## Operation
- Load-use detect: LoadUseStall = ValidE & MemReadE & (RdE != 0) & ValidD & ((RdE == Rs1D) | (RdE == Rs2D)).
- Per-edge update, highest priority first:
  1. FlushE=1: bubble.
  2. StallE=1: hold every E output unchanged.
  3. LoadUseStall=1: bubble.
  4. Otherwise: load all D inputs. ValidE takes ValidD.
- Bubble definition:
  - ValidE, RegWriteE, MemWriteE, MemReadE, BranchE and ALUControlE are cleared to 0.
  - ALUSrcE and ResultSrcE are cleared to 0.
  - PCE, RD1E, RD2E, ImmExtE, Rs1E, Rs2E and RdE load the D inputs. Their values are don't-care downstream.
- Architectural side effects: a bubble must never assert RegWriteE, MemWriteE or any bit of BranchE.
- Stall duration: a load-use stall lasts exactly one cycle. The bubble clears MemReadE, so the condition drops on the next cycle.
- FlushE together with LoadUseStall: the flush bubble is inserted. LoadUseStall still reports 1 combinationally that cycle; the top level gives flush priority on the IF/ID side.
- Register x0: RdE = 0 never causes a stall.

## Timing
- Reset (rst_n low, asynchronous): every E output and BubbleCount go to 0 immediately and hold at 0 until the first rising edge after rst_n rises.
- Latency: D inputs appear on E outputs one cycle after capture.
- LoadUseStall is purely combinational from the current E state and D inputs. It has no registered delay and must be settled before the same edge that inserts the bubble.
- Reset mid-stall: the pipeline contents are lost. After reset, ValidE = 0 and LoadUseStall = 0.
- A stall (StallE) held for N cycles keeps the E outputs constant for N edges. LoadUseStall is re-evaluated each cycle against the held E state.

## Configuration
- ID_EX_BUBBLE_CNT_EN defined:
  - BubbleCount port and a 32-bit counter are present.
  - The counter increments by 1 on every edge where priority rule 1 or 3 applies.
  - Edges where StallE holds the register do not count.
  - The counter saturates at 0xFFFFFFFF and resets to 0.
- ID_EX_BUBBLE_CNT_EN undefined: the port and counter are absent. Stage behaviour is otherwise identical.

## Test plan
- Reset then single pass:
  - Stimulus: release rst_n; drive ValidD=1, RegWriteD=1, ALUControlD=3'b010, RD1D=0x11, RdD=5.
  - Required: the next edge gives ValidE=1, RegWriteE=1, ALUControlE=3'b010, RD1E=0x11, RdE=5.
- Load-use:
  - Stimulus: EX holds a valid load with RdE=7; D has Rs2D=7.
  - Required: LoadUseStall=1 that cycle; the next edge gives a bubble (ValidE=0, RegWriteE=0, MemReadE=0) and LoadUseStall drops to 0.
- x0 and invalid:
  - Stimulus: a load with RdE=0 and Rs1D=0; separately, RdE=7 with ValidE=0.
  - Required: LoadUseStall=0 in both cases; the D instruction passes.
- Flush versus stall:
  - Stimulus: FlushE=1 and StallE=1 on the same edge, with a store in D.
  - Required: MemWriteE=0 and ValidE=0 after the edge.
- Hold:
  - Stimulus: StallE=1 for 3 cycles while the D inputs change every cycle.
  - Required: the E outputs stay constant, and BubbleCount is unchanged (macro on).
- Counter:
  - Stimulus (macro on): 2 flushes and 1 load-use bubble, then rst_n pulsed mid-cycle.
  - Required: BubbleCount reads 3 before reset and 0 immediately on rst_n low.
